// File: rtl/cia_edgedet_multi.sv
// Multi-channel synchronized edge detector for the CIA pins (FLAG, CNT, TOD, SP).
// Each channel runs a synchronizer chain and a glitch filter, then qualifies the edge
// direction and holds one pending edge until it is handed out on a phi2_dn strobe.
module cia_edgedet_multi #(
    parameter int unsigned N           = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 1,
    parameter logic        INIT_LVL    = 1'b1,
    parameter bit          HOLD_IN_RES = 1'b0
) (
    input  logic           clk,
    input  logic           res,
    input  logic           phi2_dn,
    input  logic [N-1:0]   pad_i,
    input  logic [2*N-1:0] edge_sel,
    output logic [N-1:0]   edge_o,
    output logic [N-1:0]   overrun_o,
    output logic [N-1:0]   level_o
);

    localparam int unsigned   CW      = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(FILT_LEN - 1);
    localparam logic [N-1:0]  INIT_V  = {N{INIT_LVL}};

    // In TOD mode res never resets state; it only holds off the clear.
    logic full_rst;
    assign full_rst = res && !HOLD_IN_RES;

    logic [N-1:0] sync_w;

    if (SYNC_STAGES == 0) begin : g_nosync
        assign sync_w = pad_i;
    end else begin : g_sync
        logic [N-1:0] sync_q [SYNC_STAGES];

        // Metastability chain, pad enters at stage 0.
        always_ff @(posedge clk) begin
            if (full_rst) begin
                for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
                    sync_q[k] <= INIT_V;
                end
            end else begin
                sync_q[0] <= pad_i;
                for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                    sync_q[k] <= sync_q[k-1];
                end
            end
        end

        assign sync_w = sync_q[SYNC_STAGES-1];
    end

    logic [N-1:0]  lvl_q, lvl_d;
    logic [CW-1:0] cnt_q [N];
    logic [CW-1:0] cnt_d [N];
    logic [N-1:0]  pend_q, pend_d;
    logic [N-1:0]  ovp_q, ovp_d;
    logic [N-1:0]  edge_q, edge_d;
    logic [N-1:0]  ovr_q, ovr_d;
    logic [N-1:0]  ev_c;

    // Filter, edge qualification, pending/overrun bookkeeping and phi2_dn hand-off.
    always_comb begin
        lvl_d  = lvl_q;
        cnt_d  = cnt_q;
        pend_d = pend_q;
        ovp_d  = ovp_q;
        edge_d = edge_q;
        ovr_d  = ovr_q;
        ev_c   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (sync_w[i] == lvl_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                lvl_d[i] = sync_w[i];
                cnt_d[i] = '0;
                ev_c[i]  = sync_w[i] ? edge_sel[2*i] : edge_sel[2*i+1];
            end else begin
                cnt_d[i] = CW'(cnt_q[i] + 1'b1);
            end

            // While the edge is being presented, new edges are dropped.
            if (edge_q[i] && !(HOLD_IN_RES && res)) begin
                pend_d[i] = 1'b0;
                ovp_d[i]  = 1'b0;
            end else if (ev_c[i]) begin
                if (pend_q[i]) begin
                    ovp_d[i] = 1'b1;
                end else begin
                    pend_d[i] = 1'b1;
                end
            end
        end
        if (phi2_dn) begin
            edge_d = pend_q;
            ovr_d  = ovp_q;
        end
    end

    // State registers; a full reset overrides phi2_dn.
    always_ff @(posedge clk) begin
        if (full_rst) begin
            lvl_q  <= INIT_V;
            pend_q <= '0;
            ovp_q  <= '0;
            edge_q <= '0;
            ovr_q  <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            lvl_q  <= lvl_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            ovp_q  <= ovp_d;
            edge_q <= edge_d;
            ovr_q  <= ovr_d;
        end
    end

    assign edge_o    = edge_q;
    assign overrun_o = ovr_q;
    assign level_o   = lvl_q;

endmodule
